// File: rtl/i2c_master_ctrl.sv
// I2C register-access master: one-byte register write or read over open-drain SCL/SDA.
// Each bit lasts four quarters of CLK_DIV pclk cycles; all bus outputs are registered.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       pclk,
  input  logic       vb_rst_n,
  input  logic       i2c_enable,
  input  logic       i2c_read_write,
  input  logic [6:0] i2c_device_address,
  input  logic [7:0] i2c_register_address,
  input  logic [7:0] i2c_mosi_data,
  output logic       i2c_busy,
  output logic [7:0] i2c_miso_data,
  output logic       i2c_ack_error,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  // Byte states sit directly before their ACK state; the byte->ACK step relies on it.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_ADDR       = 4'd2,
    ST_ADDR_ACK   = 4'd3,
    ST_REG        = 4'd4,
    ST_REG_ACK    = 4'd5,
    ST_DATA       = 4'd6,
    ST_DATA_ACK   = 4'd7,
    ST_RSTART     = 4'd8,
    ST_ADDR_R     = 4'd9,
    ST_ADDR_R_ACK = 4'd10,
    ST_READ       = 4'd11,
    ST_MNACK      = 4'd12,
    ST_STOP       = 4'd13
  } state_e;

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  miso_q, miso_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  dat_q, dat_d;
  logic        rw_q, rw_d;
  logic        samp_q, samp_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic [1:0]  sync_q;
  logic        sda_s, tick_s, bit_end_s;

  // Line drive per state/quarter: {scl_oe, sda_oe}, 1 = pull low.
  function automatic logic [1:0] bus_drive(input state_e st, input logic [1:0] qtr, input logic txb);
    logic scl, sda;
    scl = (qtr == 2'd0) || (qtr == 2'd3);
    case (st)
      ST_IDLE:                             begin scl = 1'b0; sda = 1'b0; end
      ST_START, ST_RSTART:                 sda = qtr[1];
      ST_STOP:                             begin scl = (qtr == 2'd0); sda = ~qtr[1]; end
      ST_ADDR, ST_REG, ST_DATA, ST_ADDR_R: sda = ~txb;
      default:                             sda = 1'b0;
    endcase
    return {scl, sda};
  endfunction

  assign i2c_busy      = busy_q;
  assign i2c_miso_data = miso_q;
  assign i2c_ack_error = err_q;
  assign scl_oe        = scl_q;
  assign sda_oe        = sda_q;
  assign sda_s         = sync_q[1];

  // Two-flop synchronizer for the SDA pad
  always_ff @(posedge pclk or negedge vb_rst_n) begin
    if (!vb_rst_n) sync_q <= 2'b11;
    else           sync_q <= {sync_q[0], sda_in};
  end

  // Controller state and output registers
  always_ff @(posedge pclk or negedge vb_rst_n) begin
    if (!vb_rst_n) begin
      state_q <= ST_IDLE;  div_q  <= 16'd0; qtr_q  <= 2'd0;  bit_q <= 4'd0;
      sh_q    <= 8'd0;     rx_q   <= 7'd0;  miso_q <= 8'd0;  dev_q <= 7'd0;
      reg_q   <= 8'd0;     dat_q  <= 8'd0;  rw_q   <= 1'b0;  samp_q <= 1'b0;
      busy_q  <= 1'b0;     err_q  <= 1'b0;  scl_q  <= 1'b0;  sda_q <= 1'b0;
    end else begin
      state_q <= state_d;  div_q  <= div_d; qtr_q  <= qtr_d; bit_q <= bit_d;
      sh_q    <= sh_d;     rx_q   <= rx_d;  miso_q <= miso_d; dev_q <= dev_d;
      reg_q   <= reg_d;    dat_q  <= dat_d; rw_q   <= rw_d;  samp_q <= samp_d;
      busy_q  <= busy_d;   err_q  <= err_d; scl_q  <= scl_d; sda_q <= sda_d;
    end
  end

  // Next-state: quarter timing, bit sequencing, ACK handling and line drive
  always_comb begin
    state_d = state_q; div_d  = div_q;  qtr_d  = qtr_q;  bit_d = bit_q;
    sh_d    = sh_q;    rx_d   = rx_q;   miso_d = miso_q; dev_d = dev_q;
    reg_d   = reg_q;   dat_d  = dat_q;  rw_d   = rw_q;   samp_d = samp_q;
    busy_d  = busy_q;  err_d  = err_q;
    tick_s    = (state_q != ST_IDLE) && (div_q == DIV_MAX);
    bit_end_s = tick_s && (qtr_q == 2'd3);

    if (state_q == ST_IDLE) begin
      if (i2c_enable) begin
        state_d = ST_START;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        rw_d    = i2c_read_write;
        dev_d   = i2c_device_address;
        reg_d   = i2c_register_address;
        dat_d   = i2c_mosi_data;
        div_d   = 16'd0;
        qtr_d   = 2'd0;
        bit_d   = 4'd0;
      end else begin
        busy_d  = 1'b0;
      end
    end else begin
      div_d = tick_s ? 16'd0 : div_q + 16'd1;
      qtr_d = tick_s ? qtr_q + 2'd1 : qtr_q;
      // SDA is sampled once per bit, at the end of Q2 while SCL is high
      if (tick_s && (qtr_q == 2'd2)) begin
        samp_d = sda_s;
        if (state_q == ST_READ) begin
          rx_d   = {rx_q[5:0], sda_s};
          miso_d = (bit_q == 4'd7) ? {rx_q, sda_s} : miso_q;
        end else begin
          rx_d   = rx_q;
        end
      end else begin
        samp_d = samp_q;
      end
      if (bit_end_s) begin
        case (state_q)
          ST_START:  begin state_d = ST_ADDR;   sh_d = {dev_q, 1'b0}; bit_d = 4'd0; end
          ST_RSTART: begin state_d = ST_ADDR_R; sh_d = {dev_q, 1'b1}; bit_d = 4'd0; end
          ST_ADDR, ST_REG, ST_DATA, ST_ADDR_R: begin
            sh_d = {sh_q[6:0], sh_q[7]};
            if (bit_q == 4'd7) begin
              state_d = state_e'(state_q + 4'd1);
              bit_d   = 4'd0;
            end else begin
              bit_d   = bit_q + 4'd1;
            end
          end
          ST_ADDR_ACK: begin
            err_d   = samp_q;
            state_d = samp_q ? ST_STOP : ST_REG;
            sh_d    = reg_q;
          end
          ST_REG_ACK: begin
            err_d   = samp_q;
            state_d = samp_q ? ST_STOP : (rw_q ? ST_RSTART : ST_DATA);
            sh_d    = dat_q;
          end
          ST_DATA_ACK:   begin err_d = samp_q; state_d = ST_STOP; end
          ST_ADDR_R_ACK: begin err_d = samp_q; state_d = samp_q ? ST_STOP : ST_READ; bit_d = 4'd0; end
          ST_READ: begin
            if (bit_q == 4'd7) begin
              state_d = ST_MNACK;
              bit_d   = 4'd0;
            end else begin
              bit_d   = bit_q + 4'd1;
            end
          end
          ST_MNACK: state_d = ST_STOP;
          ST_STOP:  begin state_d = ST_IDLE; busy_d = 1'b0; end
          default:  begin state_d = ST_IDLE; busy_d = 1'b0; end
        endcase
      end else begin
        state_d = state_q;
      end
    end

    {scl_d, sda_d} = bus_drive(state_d, qtr_d, sh_d[7]);
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: open-drain bus with a responder, a bus decoder and a
// transaction-level model predicting busy length, bus tokens, ack_error and read data.
module tb_i2c_master_ctrl;
  localparam int N = 4;

  logic       pclk = 1'b0;
  logic       vb_rst_n = 1'b1;
  logic       i2c_enable = 1'b0;
  logic       i2c_read_write = 1'b0;
  logic [6:0] i2c_device_address = 7'h00;
  logic [7:0] i2c_register_address = 8'h00;
  logic [7:0] i2c_mosi_data = 8'h00;
  logic       i2c_busy, i2c_ack_error, scl_oe, sda_oe, sda_in;
  logic [7:0] i2c_miso_data;

  logic       slv_pull = 1'b0;
  logic       cfg_nack = 1'b0;
  logic [7:0] cfg_rdata = 8'hA5;
  wire        scl_line = ~scl_oe;
  wire        sda_line = ~sda_oe & ~slv_pull;
  assign sda_in = sda_line;

  i2c_master_ctrl #(.CLK_DIV(N)) dut (
    .pclk(pclk), .vb_rst_n(vb_rst_n), .i2c_enable(i2c_enable),
    .i2c_read_write(i2c_read_write), .i2c_device_address(i2c_device_address),
    .i2c_register_address(i2c_register_address), .i2c_mosi_data(i2c_mosi_data),
    .i2c_busy(i2c_busy), .i2c_miso_data(i2c_miso_data), .i2c_ack_error(i2c_ack_error),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  always #5 pclk = ~pclk;

  // Bus tokens: 0..255 byte, 'h100 START, 'h200 STOP, 'h300 ACK, 'h301 NACK
  int obs_q[$];
  int exp_q[$];
  int checks = 0, errors = 0;
  int k = 0;
  logic [7:0] mon_sh = 8'h00;
  logic rd_mode = 1'b0;
  int rem = 0, cur_len = 0, last_len = 0;
  logic exp_err = 1'b0;
  logic [7:0] exp_miso = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus decoder: bits on SCL rise, START/STOP on SDA edges with SCL high
  initial forever begin
    int pos;
    @(posedge scl_line);
    pos = k % 9;
    if (pos < 8) begin
      mon_sh = {mon_sh[6:0], sda_line};
      if (pos == 7) begin
        obs_q.push_back(int'(mon_sh));
        if (k == 7) rd_mode = sda_line;
      end
    end else begin
      obs_q.push_back(32'h300 | int'(sda_line));
    end
    k++;
  end

  initial forever begin
    @(negedge sda_line);
    if (scl_line === 1'b1) begin obs_q.push_back(32'h100); k = 0; rd_mode = 1'b0; end
  end

  initial forever begin
    @(posedge sda_line);
    if (scl_line === 1'b1) begin obs_q.push_back(32'h200); k = 0; end
  end

  // Responder: updates SDA while SCL is low for the upcoming bit
  initial forever begin
    int sp, sph;
    @(negedge scl_line);
    sp  = k % 9;
    sph = k / 9;
    if (sp == 8) slv_pull = (sph == 0) ? ~cfg_nack : ~rd_mode;
    else         slv_pull = rd_mode && (sph == 1) && !cfg_rdata[7 - sp];
  end

  // Transaction model: on acceptance predict busy cycles, bus tokens and final status
  initial forever begin
    @(posedge pclk or negedge vb_rst_n);
    if (!vb_rst_n) begin
      rem = 0; exp_err = 1'b0; exp_miso = 8'h00; exp_q.delete();
    end else if (rem > 0) begin
      rem--;
    end else if (i2c_enable) begin
      int bits;
      exp_q.push_back(32'h100);
      exp_q.push_back(int'({i2c_device_address, 1'b0}));
      exp_q.push_back(32'h300 | int'(cfg_nack));
      if (cfg_nack) begin
        bits = 1 + 9 + 1;
      end else begin
        exp_q.push_back(int'(i2c_register_address));
        exp_q.push_back(32'h300);
        if (i2c_read_write) begin
          exp_q.push_back(32'h100);
          exp_q.push_back(int'({i2c_device_address, 1'b1}));
          exp_q.push_back(32'h300);
          exp_q.push_back(int'(cfg_rdata));
          exp_q.push_back(32'h301);
          exp_miso = cfg_rdata;
          bits = 1 + 9 + 9 + 1 + 9 + 9 + 1;
        end else begin
          exp_q.push_back(int'(i2c_mosi_data));
          exp_q.push_back(32'h300);
          bits = 1 + 9 + 9 + 9 + 1;
        end
      end
      exp_q.push_back(32'h200);
      exp_err = cfg_nack;
      rem = 4 * N * bits;
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge pclk);
    if (vb_rst_n) begin
      chk("busy", i2c_busy, rem > 0);
      if (rem == 0) begin
        chk("ack_error", i2c_ack_error, exp_err);
        chk("miso_data", i2c_miso_data, exp_miso);
        chk("idle_scl_oe", scl_oe, 1'b0);
        chk("idle_sda_oe", sda_oe, 1'b0);
      end
      if (i2c_busy) cur_len++;
      else if (cur_len > 0) begin last_len = cur_len; cur_len = 0; end
    end else begin
      cur_len = 0;
    end
  end

  task automatic flush_bus();
    obs_q.delete(); k = 0; rd_mode = 1'b0; slv_pull = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input string name);
    int n = 0;
    while (i2c_busy !== val && n < 3000) begin @(negedge pclk); n++; end
    chk(name, i2c_busy, val);
  endtask

  task automatic start_txn(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    @(negedge pclk);
    i2c_read_write = rw; i2c_device_address = dev; i2c_register_address = ra; i2c_mosi_data = wd;
    i2c_enable = 1'b1;
    @(negedge pclk);
    i2c_enable = 1'b0;
    chk("accept_busy", i2c_busy, 1'b1);
  endtask

  task automatic finish_txn();
    wait_busy(1'b0, "txn_done");
    @(negedge pclk);
  endtask

  task automatic lit(input int idx, input int val, input string name);
    chk(name, (idx < obs_q.size()) ? obs_q[idx] : -1, val);
  endtask

  task automatic compare_bus(input string name);
    chk({name, "_token_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_token%0d", name, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1 vb_rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    flush_bus();
    chk("rst_busy", i2c_busy, 1'b0);
    chk("rst_err", i2c_ack_error, 1'b0);
    chk("rst_miso", i2c_miso_data, 8'h00);
    chk("rst_scl", scl_oe, 1'b0);
    chk("rst_sda", sda_oe, 1'b0);
    vb_rst_n = 1'b1;
    @(negedge pclk);

    // Register write
    start_txn(1'b0, 7'h18, 8'h0B, 8'h81);
    finish_txn();
    lit(1, 'h30, "wr_addr_byte"); lit(3, 'h0B, "wr_reg_byte"); lit(5, 'h81, "wr_data_byte");
    chk("wr_busy_len", last_len, 464);
    chk("wr_ack_err", i2c_ack_error, 1'b0);
    compare_bus("wr");

    // Register read
    start_txn(1'b1, 7'h18, 8'h00, 8'h00);
    finish_txn();
    lit(5, 'h100, "rd_rstart"); lit(6, 'h31, "rd_addr_r_byte");
    lit(8, 'hA5, "rd_data_byte"); lit(9, 'h301, "rd_master_nack");
    chk("rd_miso", i2c_miso_data, 8'hA5);
    chk("rd_busy_len", last_len, 624);
    compare_bus("rd");

    // NACK on the first address byte
    cfg_nack = 1'b1;
    start_txn(1'b0, 7'h18, 8'h0B, 8'h81);
    finish_txn();
    chk("nack_token_count", obs_q.size(), 4);
    lit(2, 'h301, "nack_addr_nack"); lit(3, 'h200, "nack_stop");
    chk("nack_err", i2c_ack_error, 1'b1);
    chk("nack_busy_len", last_len, 176);
    chk("nack_miso_kept", i2c_miso_data, 8'hA5);
    compare_bus("nack");
    cfg_nack = 1'b0;

    // Enable pulse with new inputs mid-transaction is ignored
    start_txn(1'b0, 7'h18, 8'h0B, 8'h81);
    repeat (100) @(negedge pclk);
    i2c_read_write = 1'b1; i2c_device_address = 7'h55; i2c_register_address = 8'hEE; i2c_mosi_data = 8'h12;
    i2c_enable = 1'b1;
    @(negedge pclk);
    i2c_enable = 1'b0;
    finish_txn();
    lit(1, 'h30, "mid_addr_byte"); lit(3, 'h0B, "mid_reg_byte"); lit(5, 'h81, "mid_data_byte");
    chk("mid_busy_len", last_len, 464);
    compare_bus("mid");
    repeat (20) @(negedge pclk);
    chk("mid_no_second_busy", i2c_busy, 1'b0);
    chk("mid_no_second_bus", obs_q.size(), 0);

    // Reset during the REG byte, then a normal write
    start_txn(1'b0, 7'h18, 8'h0B, 8'h81);
    repeat (170) @(posedge pclk);
    chk("pre_rst_busy", i2c_busy, 1'b1);
    #2 vb_rst_n = 1'b0;
    #1;
    chk("midrst_scl", scl_oe, 1'b0);
    chk("midrst_sda", sda_oe, 1'b0);
    chk("midrst_busy", i2c_busy, 1'b0);
    chk("midrst_miso", i2c_miso_data, 8'h00);
    flush_bus();
    repeat (2) @(negedge pclk);
    vb_rst_n = 1'b1;
    start_txn(1'b0, 7'h18, 8'h3C, 8'h5A);
    finish_txn();
    lit(3, 'h3C, "postrst_reg_byte"); lit(5, 'h5A, "postrst_data_byte");
    chk("postrst_busy_len", last_len, 464);
    compare_bus("postrst");

    // Back-to-back with enable held: NACKed write then ACKed write
    cfg_nack = 1'b1;
    @(negedge pclk);
    i2c_read_write = 1'b0; i2c_device_address = 7'h18; i2c_register_address = 8'h0B; i2c_mosi_data = 8'h81;
    i2c_enable = 1'b1;
    wait_busy(1'b1, "b2b_first_start");
    wait_busy(1'b0, "b2b_first_done");
    chk("b2b_first_err", i2c_ack_error, 1'b1);
    cfg_nack = 1'b0;
    begin
      int g = 0;
      while (!i2c_busy && g < 20) begin g++; @(negedge pclk); end
      chk("b2b_idle_gap", g, 1);
    end
    chk("b2b_first_len", last_len, 176);
    i2c_enable = 1'b0;
    finish_txn();
    chk("b2b_second_len", last_len, 464);
    chk("b2b_second_err", i2c_ack_error, 1'b0);
    compare_bus("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning pclk cycles per SCL quarter-period (range 2..65535).
REQ-002 SHALL have port pclk, input, 1, the only clock; all logic rises on pclk.
REQ-003 SHALL have port vb_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i2c_enable, input, 1, transaction request; sampled only in IDLE.
REQ-005 SHALL have port i2c_read_write, input, 1; 0 = register write, 1 = register read.
REQ-006 SHALL have port i2c_device_address, input, 7, the 7-bit target address.
REQ-007 SHALL have port i2c_register_address, input, 8, the target register index.
REQ-008 SHALL have port i2c_mosi_data, input, 8, the write payload.
REQ-009 SHALL have port i2c_busy, output, 1, high from accept to the end of STOP.
REQ-010 SHALL have port i2c_miso_data, output, 8, the read result.
REQ-011 SHALL have port i2c_ack_error, output, 1, set when the target NACKs.
REQ-012 SHALL have port scl_oe, output, 1; 1 = drive SCL low, 0 = release SCL.
REQ-013 SHALL have port sda_oe, output, 1; 1 = drive SDA low, 0 = release SDA.
REQ-014 SHALL have port sda_in, input, 1, the SDA pad value, passed through a 2-flop synchronizer before use.

Function
REQ-015 SHALL generate a quarter tick every CLK_DIV pclk cycles while not IDLE; one bit time = 4 ticks (Q0..Q3).
REQ-016 SHALL hold SCL low in Q0 and Q3 and release it in Q1 and Q2; SDA changes only at the Q0 start.
REQ-017 SHALL sample SDA (ACK bits, read bits) at the end of Q2.
REQ-018 SHALL, in IDLE with i2c_enable=1, latch all request inputs, assert i2c_busy on the next cycle, clear i2c_ack_error, and enter START.
REQ-019 SHALL ignore i2c_enable while i2c_busy=1; latched inputs SHALL NOT change mid-transaction.
REQ-020 SHALL sequence states IDLE -> START -> ADDR -> ADDR_ACK -> REG -> REG_ACK, then DATA -> DATA_ACK -> STOP for writes.
REQ-021 SHALL, for reads, go REG_ACK -> RSTART -> ADDR_R -> ADDR_R_ACK -> READ -> MNACK -> STOP.
REQ-022 SHALL implement START/RSTART as one bit time: SDA released in Q0–Q1, pulled low in Q2 with SCL high, SCL low in Q3.
REQ-023 SHALL implement STOP as one bit time: SDA low in Q0–Q1, SCL released from Q1, SDA released in Q2–Q3.
REQ-024 SHALL send bytes MSB first; ADDR byte = {addr,0}; ADDR_R byte = {addr,1}.
REQ-025 SHALL release SDA during the ACK bit; if the sampled SDA is 1, it SHALL set i2c_ack_error and go straight to STOP.
REQ-026 SHALL shift READ bits into i2c_miso_data, update it only after all 8 bits, drive SDA released (NACK) in MNACK, and leave i2c_miso_data unchanged on a read aborted by NACK.
REQ-027 SHALL deassert i2c_busy in the cycle IDLE is re-entered after STOP Q3.
REQ-028 SHALL, with CLK_DIV=N, keep i2c_busy high for exactly 29*4*N cycles for a write, 39*4*N for a read, and 11*4*N for a NACK on the first address.
REQ-029 SHALL count bits with a 4-bit counter, reloaded per byte; no wrap beyond 9 bits per byte phase.
REQ-030 SHALL NOT support clock stretching or arbitration loss.

Reset
REQ-031 SHALL, when vb_rst_n=0, immediately clear outputs: i2c_busy=0, i2c_ack_error=0, i2c_miso_data=0x00, scl_oe=0, sda_oe=0, state=IDLE, counters=0.
REQ-032 SHALL, on reset mid-transaction, release both lines immediately without a STOP; after reset release, the first request SHALL proceed normally.

Verification
REQ-033 CLK_DIV=4, write dev 0x18 reg 0x0B data 0x81, responder ACKs -> SDA bytes 0x30, 0x0B, 0x81, busy for 464 cycles, ack_error=0.
REQ-034 CLK_DIV=4, read dev 0x18 reg 0x00, responder returns 0xA5 -> bytes 0x30, 0x00, RSTART, 0x31, master NACK, STOP; i2c_miso_data=0xA5; busy for 624 cycles.
REQ-035 Responder NACKs first address byte -> STOP follows, ack_error=1, busy for 176 cycles, no REG byte seen.
REQ-036 Pulse i2c_enable mid-transaction with new inputs -> no effect, bus bytes unchanged, no second transaction.
REQ-037 Assert vb_rst_n=0 during REG byte -> scl_oe=sda_oe=0 and busy=0 with no pclk edge; following write completes correctly.
REQ-038 Hold i2c_enable high for back-to-back writes -> IDLE lasts one cycle, next START begins, ack_error cleared per transaction.
